// File: rtl/cpu_load_store_unit_if.sv
// Purpose: EX/MEM operation handshake, req/ack memory port and WB/exception return of the load/store unit.
// Latency: none, signal bundle only.
// Backpressure: o_ready from the unit stalls the issuing stage; mem_ack completes a held mem_req.
interface cpu_load_store_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                i_valid;
    logic                o_ready;
    logic                i_mem;
    logic                i_store;
    logic [2:0]          i_funct3;
    logic [4:0]          i_rd;
    logic [XLEN-1:0]     i_data_in;
    logic [XLEN-1:0]     i_store_data;

    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [XLEN/8-1:0]   mem_be;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_ack;
    logic [XLEN-1:0]     mem_rdata;

    logic                o_wb_valid;
    logic                o_rd_we;
    logic [4:0]          o_rd;
    logic [XLEN-1:0]     o_rd_output;
    logic                o_exc;
    logic [1:0]          o_exc_cause;
    logic [XLEN-1:0]     o_exc_addr;

    // Load/store unit side.
    modport slave (
        input  i_valid, i_mem, i_store, i_funct3, i_rd, i_data_in, i_store_data,
        input  mem_ack, mem_rdata,
        output o_ready, mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output o_wb_valid, o_rd_we, o_rd, o_rd_output, o_exc, o_exc_cause, o_exc_addr
    );

    // Pipeline and memory side.
    modport master (
        output i_valid, i_mem, i_store, i_funct3, i_rd, i_data_in, i_store_data,
        output mem_ack, mem_rdata,
        input  o_ready, mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  o_wb_valid, o_rd_we, o_rd, o_rd_output, o_exc, o_exc_cause, o_exc_addr
    );
endinterface

// File: rtl/cpu_load_store_unit.sv
// Purpose: MEM-stage load/store unit: lane alignment, req/ack memory access, load extension, fault flagging.
// Latency: non-memory op 1 cycle; memory op 1 cycle to mem_req, retire 1 cycle after mem_ack.
// Backpressure: o_ready is low while an access is outstanding; mem_* held stable until mem_ack.
module cpu_load_store_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_load_store_unit_if.slave bus
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              legal;
    logic              misaligned;
    logic [2:0]        align_mask;
    logic [NB-1:0]     size_mask;
    logic [XLEN-1:0]   data_mask;
    logic [OFS-1:0]    ofs;

    logic [OFS-1:0]    ofs_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [NB-1:0]     mem_be_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic              wb_valid_q;
    logic              rd_we_q;
    logic [4:0]        rd_out_q;
    logic [XLEN-1:0]   rd_output_q;
    logic              exc_q;
    logic [1:0]        exc_cause_q;
    logic [XLEN-1:0]   exc_addr_q;
    logic [XLEN-1:0]   rdata_sh;
    logic [XLEN-1:0]   load_val;

    // mem_req comes straight from the state so an async reset withdraws it at once.
    assign bus.o_ready     = (state == IDLE);
    assign bus.mem_req     = (state == WAIT);
    assign accept          = bus.i_valid && (state == IDLE);
    assign ofs             = bus.i_data_in[OFS-1:0];

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.o_wb_valid  = wb_valid_q;
    assign bus.o_rd_we     = rd_we_q;
    assign bus.o_rd        = rd_out_q;
    assign bus.o_rd_output = rd_output_q;
    assign bus.o_exc       = exc_q;
    assign bus.o_exc_cause = exc_cause_q;
    assign bus.o_exc_addr  = exc_addr_q;

    // Decode funct3 into legality, alignment check and byte/bit lane masks of the access size.
    always_comb begin
        align_mask = 3'b000;
        size_mask  = '0;
        data_mask  = '0;
        case (bus.i_funct3[1:0])
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        if (bus.i_store) begin
            legal = (bus.i_funct3 inside {3'b000, 3'b001, 3'b010}) ||
                    (bus.i_funct3 == 3'b011 && XLEN == 64);
        end else begin
            legal = (bus.i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                    ((bus.i_funct3 == 3'b011 || bus.i_funct3 == 3'b110) && XLEN == 64);
        end
        misaligned = |(bus.i_data_in[2:0] & align_mask);
        for (int i = 0; i < NB; i++) begin
            size_mask[i]     = (i < (1 << bus.i_funct3[1:0]));
            data_mask[8*i+:8] = {8{size_mask[i]}};
        end
    end

    // Pull the addressed lanes of the read data down to bit 0 and extend them.
    always_comb begin
        rdata_sh = bus.mem_rdata >> {ofs_q, 3'b000};
        case (funct3_q)
            3'b000:  load_val = XLEN'($signed(rdata_sh[7:0]));
            3'b001:  load_val = XLEN'($signed(rdata_sh[15:0]));
            3'b010:  load_val = XLEN'($signed(rdata_sh[31:0]));
            3'b100:  load_val = XLEN'(rdata_sh[7:0]);
            3'b101:  load_val = XLEN'(rdata_sh[15:0]);
            3'b110:  load_val = XLEN'(rdata_sh[31:0]);
            default: load_val = rdata_sh;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Enter WAIT only for a clean memory op; leave when the memory acknowledges.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && bus.i_mem && legal && !misaligned) state_nxt = WAIT;
            WAIT: if (bus.mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture accepted ops, drive the memory port from registers, and produce retire/exception pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ofs_q       <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            rd_we_q     <= 1'b0;
            rd_out_q    <= '0;
            rd_output_q <= '0;
            exc_q       <= 1'b0;
            exc_cause_q <= '0;
            exc_addr_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            exc_q      <= 1'b0;
            if (accept) begin
                if (!bus.i_mem) begin
                    wb_valid_q  <= 1'b1;
                    rd_we_q     <= 1'b1;
                    rd_out_q    <= bus.i_rd;
                    rd_output_q <= bus.i_data_in;
                end else if (!legal || misaligned) begin
                    exc_q       <= 1'b1;
                    exc_cause_q <= !legal ? 2'b11 : (bus.i_store ? 2'b10 : 2'b01);
                    exc_addr_q  <= bus.i_data_in;
                end else begin
                    ofs_q       <= ofs;
                    funct3_q    <= bus.i_funct3;
                    rd_q        <= bus.i_rd;
                    mem_addr_q  <= ADDR_W'(bus.i_data_in & ~XLEN'(NB - 1));
                    mem_we_q    <= bus.i_store;
                    mem_be_q    <= size_mask << ofs;
                    mem_wdata_q <= bus.i_store ? ((bus.i_store_data & data_mask) << {ofs, 3'b000}) : '0;
                end
            end else if (state == WAIT && bus.mem_ack) begin
                wb_valid_q  <= 1'b1;
                rd_we_q     <= !mem_we_q;
                rd_out_q    <= rd_q;
                rd_output_q <= mem_we_q ? '0 : load_val;
            end
        end
    end
endmodule

// File: tb/tb_cpu_load_store_unit.sv
// Purpose: randomized and directed check of cpu_load_store_unit at XLEN 32 and 64 against a byte-level model.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: memory ack delay varied per access; i_valid held high during WAIT.
module tb_cpu_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_load_store_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();
    cpu_load_store_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

    cpu_load_store_unit #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
    cpu_load_store_unit #(.XLEN(64), .ADDR_W(32)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));

    // Shared stimulus; sel picks which unit receives valid/ack and which one is observed.
    logic        sel;
    logic        drv_valid, drv_mem, drv_store, drv_ack;
    logic [2:0]  drv_f3;
    logic [4:0]  drv_rd;
    logic [63:0] drv_data, drv_sdata, drv_rdata;

    assign b32.i_valid      = drv_valid & ~sel;
    assign b32.i_mem        = drv_mem;
    assign b32.i_store      = drv_store;
    assign b32.i_funct3     = drv_f3;
    assign b32.i_rd         = drv_rd;
    assign b32.i_data_in    = drv_data[31:0];
    assign b32.i_store_data = drv_sdata[31:0];
    assign b32.mem_ack      = drv_ack & ~sel;
    assign b32.mem_rdata    = drv_rdata[31:0];

    assign b64.i_valid      = drv_valid & sel;
    assign b64.i_mem        = drv_mem;
    assign b64.i_store      = drv_store;
    assign b64.i_funct3     = drv_f3;
    assign b64.i_rd         = drv_rd;
    assign b64.i_data_in    = drv_data;
    assign b64.i_store_data = drv_sdata;
    assign b64.mem_ack      = drv_ack & sel;
    assign b64.mem_rdata    = drv_rdata;

    logic        obs_ready, obs_req, obs_we, obs_wb, obs_rd_we, obs_exc;
    logic [7:0]  obs_be;
    logic [31:0] obs_addr;
    logic [63:0] obs_wdata, obs_out, obs_exc_addr;
    logic [4:0]  obs_rd;
    logic [1:0]  obs_cause;

    assign obs_ready    = sel ? b64.o_ready     : b32.o_ready;
    assign obs_req      = sel ? b64.mem_req     : b32.mem_req;
    assign obs_we       = sel ? b64.mem_we      : b32.mem_we;
    assign obs_be       = sel ? b64.mem_be      : {4'b0000, b32.mem_be};
    assign obs_addr     = sel ? b64.mem_addr    : b32.mem_addr;
    assign obs_wdata    = sel ? b64.mem_wdata   : {32'b0, b32.mem_wdata};
    assign obs_wb       = sel ? b64.o_wb_valid  : b32.o_wb_valid;
    assign obs_rd_we    = sel ? b64.o_rd_we     : b32.o_rd_we;
    assign obs_rd       = sel ? b64.o_rd        : b32.o_rd;
    assign obs_out      = sel ? b64.o_rd_output : {32'b0, b32.o_rd_output};
    assign obs_exc      = sel ? b64.o_exc       : b32.o_exc;
    assign obs_cause    = sel ? b64.o_exc_cause : b32.o_exc_cause;
    assign obs_exc_addr = sel ? b64.o_exc_addr  : {32'b0, b32.o_exc_addr};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (xlen64=%0b)", tag, got, exp, sel);
        end
    endtask

    // Reference: works byte by byte from the ISA rules, independent of any shift/mask formulation.
    function automatic void model(input bit w64, input bit st, input logic [2:0] f3,
                                  input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rdat,
                                  output logic [1:0] cause, output logic [31:0] maddr,
                                  output logic [7:0] be, output logic [63:0] wd, output logic [63:0] res);
        int nb, sz, ofs;
        bit legal, sgn;
        logic [63:0] v;
        nb = w64 ? 8 : 4;
        sz = 1 << f3[1:0];
        if (st) legal = (f3 < 3'd3) || (f3 == 3'd3 && w64);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || ((f3 == 3'd3 || f3 == 3'd6) && w64);
        if (!legal)            cause = 2'b11;
        else if (a % sz != 0)  cause = st ? 2'b10 : 2'b01;
        else                   cause = 2'b00;
        ofs   = int'(a % nb);
        maddr = 32'(a - 64'(ofs));
        be = '0; wd = '0; v = '0;
        if (cause == 2'b00) begin
            for (int b = 0; b < sz; b++) begin
                be[ofs+b] = 1'b1;
                if (st) wd[8*(ofs+b)+:8] = sd[8*b+:8];
                v[8*b+:8] = rdat[8*(ofs+b)+:8];
            end
        end
        sgn = !f3[2] && (sz < nb);
        if (sgn && v[8*sz-1]) begin
            for (int b = sz; b < 8; b++) v[8*b+:8] = 8'hFF;
        end
        res = st ? 64'd0 : (w64 ? v : (v & 64'h0000_0000_FFFF_FFFF));
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, obs_ready, 1);
        chk({tag, "_req"}, obs_req, 0);
        chk({tag, "_we"}, obs_we, 0);
        chk({tag, "_be"}, obs_be, 0);
        chk({tag, "_addr"}, obs_addr, 0);
        chk({tag, "_wdata"}, obs_wdata, 0);
        chk({tag, "_wb"}, obs_wb, 0);
        chk({tag, "_rdwe"}, obs_rd_we, 0);
        chk({tag, "_rd"}, obs_rd, 0);
        chk({tag, "_out"}, obs_out, 0);
        chk({tag, "_exc"}, obs_exc, 0);
        chk({tag, "_cause"}, obs_cause, 0);
        chk({tag, "_excaddr"}, obs_exc_addr, 0);
    endtask

    // Entered just after a falling edge; issues one op and returns at the falling edge of its result.
    task automatic do_op(input bit w64, input bit mem, input bit st, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] sd,
                         input logic [63:0] rdat, input int nack);
        logic [63:0] xm, a, wd, res;
        logic [31:0] maddr;
        logic [7:0]  be;
        logic [1:0]  cause;
        xm = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a  = addr & xm;
        model(w64, st, f3, a, sd & xm, rdat & xm, cause, maddr, be, wd, res);
        sel = w64; drv_valid = 1'b1; drv_mem = mem; drv_store = st; drv_f3 = f3;
        drv_rd = rd; drv_data = addr; drv_sdata = sd; drv_ack = 1'b0;
        #1;
        chk("ready_idle", obs_ready, 1);
        @(negedge clk);
        drv_valid = 1'b0;
        if (!mem) begin
            chk("alu_wb", obs_wb, 1);
            chk("alu_rdwe", obs_rd_we, 1);
            chk("alu_rd", obs_rd, rd);
            chk("alu_out", obs_out, a);
            chk("alu_exc", obs_exc, 0);
        end else if (cause != 2'b00) begin
            chk("exc_pulse", obs_exc, 1);
            chk("exc_cause", obs_cause, cause);
            chk("exc_addr", obs_exc_addr, a);
            chk("exc_wb", obs_wb, 0);
            chk("exc_req", obs_req, 0);
            chk("exc_ready", obs_ready, 1);
        end else begin
            for (int k = 1; k <= nack; k++) begin
                chk("wait_req", obs_req, 1);
                chk("wait_ready", obs_ready, 0);
                chk("wait_wb", obs_wb, 0);
                chk("mem_addr", obs_addr, maddr);
                chk("mem_we", obs_we, st);
                chk("mem_be", obs_be, be);
                chk("mem_wdata", obs_wdata, wd);
                drv_valid = 1'b1;
                if (k == nack) begin
                    drv_ack = 1'b1; drv_rdata = rdat;
                end else begin
                    drv_ack = 1'b0; drv_rdata = {$urandom, $urandom};
                end
                @(negedge clk);
            end
            drv_valid = 1'b0; drv_ack = 1'b0;
            chk("ret_wb", obs_wb, 1);
            chk("ret_rdwe", obs_rd_we, !st);
            chk("ret_rd", obs_rd, rd);
            chk("ret_out", obs_out, res);
            chk("ret_ready", obs_ready, 1);
            chk("ret_req", obs_req, 0);
            chk("ret_exc", obs_exc, 0);
        end
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; drv_valid = 1'b0; drv_mem = 1'b0; drv_store = 1'b0;
        drv_ack = 1'b0; drv_f3 = 3'd0; drv_rd = 5'd0; drv_data = '0; drv_sdata = '0; drv_rdata = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst32");
        sel = 1'b1; #1;
        chk_reset_outputs("rst64");
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Directed cases at XLEN=32.
        do_op(0, 1, 1, 3'b000, 5'd1, 64'h1003, 64'h0000_00A5, 64'h0, 1);
        do_op(0, 1, 0, 3'b001, 5'd2, 64'h2002, 64'h0, 64'h8001_1234, 1);
        do_op(0, 1, 0, 3'b101, 5'd3, 64'h2002, 64'h0, 64'h8001_1234, 1);
        do_op(0, 1, 0, 3'b000, 5'd4, 64'h2000, 64'h0, 64'h8001_1234, 2);
        do_op(0, 1, 0, 3'b010, 5'd5, 64'h3002, 64'h0, 64'h0, 1);
        do_op(0, 1, 0, 3'b011, 5'd6, 64'h3000, 64'h0, 64'h0, 1);
        do_op(0, 1, 1, 3'b011, 5'd6, 64'h3000, 64'h0, 64'h0, 1);
        do_op(0, 1, 1, 3'b001, 5'd7, 64'h3001, 64'h1234, 64'h0, 1);
        do_op(0, 1, 0, 3'b010, 5'd8, 64'h4000, 64'h0, 64'hCAFE_F00D, 3);
        do_op(0, 0, 0, 3'b000, 5'd9, 64'h1111_2222, 64'h0, 64'h0, 1);
        do_op(0, 0, 0, 3'b000, 5'd0, 64'h3333_4444, 64'h0, 64'h0, 1);

        // Reset during the second WAIT cycle abandons the access.
        sel = 1'b0; drv_valid = 1'b1; drv_mem = 1'b1; drv_store = 1'b0; drv_f3 = 3'b010;
        drv_rd = 5'd10; drv_data = 64'h40;
        @(negedge clk);
        drv_valid = 1'b0;
        chk("rw_req1", obs_req, 1);
        @(negedge clk);
        chk("rw_req2", obs_req, 1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("rw_async");
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rw_nowb", obs_wb, 0);
        chk("rw_ready", obs_ready, 1);
        chk("rw_req3", obs_req, 0);
        do_op(0, 1, 0, 3'b100, 5'd11, 64'h41, 64'h0, 64'h0000_F700, 1);

        // Directed cases at XLEN=64.
        do_op(1, 1, 0, 3'b110, 5'd12, 64'hC, 64'h0, 64'hFFFF_FFFF_0000_0000, 1);
        do_op(1, 1, 0, 3'b010, 5'd13, 64'hC, 64'h0, 64'hFFFF_FFFF_0000_0000, 2);
        do_op(1, 1, 1, 3'b011, 5'd14, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0, 1);
        do_op(1, 1, 0, 3'b011, 5'd15, 64'h10, 64'h0, 64'h8000_0000_0000_0001, 1);
        do_op(1, 1, 0, 3'b011, 5'd15, 64'h14, 64'h0, 64'h0, 1);
        do_op(1, 1, 0, 3'b111, 5'd16, 64'h10, 64'h0, 64'h0, 1);

        // Randomized mix over both widths.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] ad;
            ad = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) ad[2:0] = 3'b000;
            if ($urandom_range(0, 1) == 1) ad[0] = 1'b0;
            do_op(1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), ad,
                  {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
